// File: rtl/myfilter_pkg.sv
// Shared filter datapath widths and helpers.
// Used by filter_unit and its output buffer.
package myfilter_pkg;

    localparam int DATABITS = 16;

    // Occupancy counter width that can represent 0..depth inclusive.
    function automatic int level_bits(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/filter_out_buffer.sv
// Elastic register FIFO between filter_unit and the system consumer; reports level and push count.
// Latency 1 clk push->out_valid, no bypass; extready_out is registered !full, no write-through when full.
module filter_out_buffer #(
    parameter int DATABITS = myfilter_pkg::DATABITS,
    parameter int DEPTH    = 8,
    parameter int AFULL    = 6,
    parameter int CNTBITS  = 16,
    localparam int LVLW    = myfilter_pkg::level_bits(DEPTH)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                flush_in,
    input  logic [DATABITS-1:0] ext_in,
    input  logic                extvalid_in,
    output logic                extready_out,
    output logic [DATABITS-1:0] out_data,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [LVLW-1:0]     level_out,
    output logic                afull_out,
    output logic [CNTBITS-1:0]  count_out
);

    localparam int PTRW = $clog2(DEPTH);

    logic [DATABITS-1:0] mem [DEPTH];

    logic [PTRW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PTRW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [LVLW-1:0]    level_q, level_d;
    logic               extready_q, extready_d;
    logic               afull_q, afull_d;
    logic [CNTBITS-1:0] count_q, count_d;

    logic push;
    logic pop;

    assign push = extvalid_in & extready_q;
    assign pop  = (level_q != '0) & out_ready;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        count_d  = count_q + CNTBITS'(push);
        if (flush_in) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + PTRW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTRW'(1);
            end
            level_d = level_q + LVLW'(push) - LVLW'(pop);
        end
        // Flags come from next-state level so they stay registered yet current.
        extready_d = (level_d != LVLW'(DEPTH));
        afull_d    = (level_d >= LVLW'(AFULL));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            extready_q <= 1'b0;
            afull_q    <= 1'b0;
            count_q    <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            extready_q <= extready_d;
            afull_q    <= afull_d;
            count_q    <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push && !flush_in) begin
            mem[wr_ptr_q] <= ext_in;
        end
    end

    assign extready_out = extready_q;
    assign out_valid    = (level_q != '0);
    assign out_data     = out_valid ? mem[rd_ptr_q] : '0;
    assign level_out    = level_q;
    assign afull_out    = afull_q;
    assign count_out    = count_q;

endmodule
